// File: rtl/button_event_gen.sv
// Turns a debounced button level into single-cycle press/release/long-press/repeat
// events and keeps a press-toggle level.
module button_event_gen #(
  parameter int unsigned LONG_TICKS   = 200,
  parameter int unsigned REPEAT_TICKS = 50,
  parameter int unsigned CNT_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic repeat_pulse,
  output logic held,
  output logic toggle_state
);

  typedef enum logic [1:0] {StIdle, StShort, StRepeat} state_e;

  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q;
  logic             press_d, release_d, long_d, repeat_d, toggle_d;
  logic             rise, fall;

  assign rise = button_level & ~level_q;
  assign fall = ~button_level;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    toggle_d  = toggle_state;
    case (state_q)
      StIdle: begin
        // A tick arriving together with the rise is deliberately not counted.
        if (rise) begin
          press_d  = 1'b1;
          toggle_d = ~toggle_state;
          cnt_d    = '0;
          state_d  = StShort;
        end
      end
      StShort: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else if (tick) begin
          if (cnt_q == LongLast) begin
            long_d  = 1'b1;
            cnt_d   = '0;
            state_d = StRepeat;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StRepeat: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else if (tick) begin
          if (cnt_q == RepeatLast) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // level_q resets high so a button held through reset never reads as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      level_q          <= 1'b1;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      repeat_pulse     <= 1'b0;
      toggle_state     <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      level_q          <= button_level;
      press_pulse      <= press_d;
      release_pulse    <= release_d;
      long_press_pulse <= long_d;
      repeat_pulse     <= repeat_d;
      toggle_state     <= toggle_d;
    end
  end

  assign held = (state_q != StIdle);

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with LONG_TICKS=4, REPEAT_TICKS=2.
module tb_button_event_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic btn = 1'b1;
  logic press_pulse, release_pulse, long_press_pulse, repeat_pulse, held, toggle_state;

  int tests = 0;
  int fails = 0;

  button_event_gen #(
    .LONG_TICKS  (4),
    .REPEAT_TICKS(2),
    .CNT_W       (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tick            (tick),
    .button_level    (btn),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .repeat_pulse    (repeat_pulse),
    .held            (held),
    .toggle_state    (toggle_state)
  );

  always #5 clk = ~clk;

  // {press, release, long, repeat, held, toggle}
  function automatic logic [5:0] outs();
    return {press_pulse, release_pulse, long_press_pulse, repeat_pulse, held, toggle_state};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic t, input logic b);
    @(negedge clk);
    rst  = r;
    tick = t;
    btn  = b;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r;
    logic       t;
    logic       b;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [5:0] stray;

  initial begin
    // Reset with button held high, then drop and raise.
    vecs.push_back('{1'b1, 1'b0, 1'b1, 6'b000000});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 6'b000000});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000000});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6'b000000});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 6'b100011});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 6'b000011});
    // Release after 3 ticks: no long press.
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000011});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000011});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000011});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6'b010001});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6'b000001});
    // Fall coincides with the 4th tick: release wins.
    vecs.push_back('{1'b0, 1'b0, 1'b1, 6'b100010});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000010});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000010});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000010});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 6'b010000});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6'b000000});
    // Tick in the rise cycle is ignored; long press then repeats every 2 ticks.
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b100011});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000011});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000011});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000011});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b001011});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000011});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000111});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 6'b000011});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000011});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 6'b000111});
    // Back-to-back presses with a single low clk between.
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6'b010001});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 6'b100010});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6'b010000});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 6'b100011});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 6'b010001});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].t, vecs[i].b);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Hold for 10 ticks at one tick per 10 clk.
    step(1'b0, 1'b0, 1'b1);
    check("hold_press", outs(), 6'b100010);
    stray = '0;
    for (int k = 1; k <= 10; k++) begin
      for (int j = 0; j < 9; j++) begin
        step(1'b0, 1'b0, 1'b1);
        stray |= {outs()[5:2], 2'b00};
      end
      step(1'b0, 1'b1, 1'b1);
      check($sformatf("hold_tick%0d", k), outs(),
            {2'b00, (k == 4), (k == 6 || k == 8 || k == 10), 2'b10});
    end
    check("hold_no_stray", stray, 6'b000000);
    step(1'b0, 1'b0, 1'b0);
    check("hold_release", outs(), 6'b010000);

    // Reset asserted while in REPEAT.
    step(1'b0, 1'b0, 1'b1);
    check("rst_press", outs(), 6'b100011);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1);
    check("rst_in_repeat", outs(), 6'b001011);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_clear", outs(), 6'b000000);
    step(1'b1, 1'b0, 1'b1);
    stray = '0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, (k % 10) == 9, 1'b1);
      stray |= outs();
    end
    check("rst_no_release", stray, 6'b000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
